// File: rtl/lwc_postproc_lite.sv
// ---------------------------------------------------------------------------
// lwc_postproc_lite
//
// Post-processor for a lightweight-crypto core. For every command it emits a
// header word, the (byte-masked) data words coming from the core, an
// optional tag section (encrypt) or tag-check step (decrypt), and finally a
// status word flagged with do_last.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   cmd_*              : operation command (valid/ready handshake)
//   bdo, bdo_valid,
//   bdo_valid_bytes,
//   bdo_ready          : data words from the crypto core
//   msg_auth_*         : tag-check result from the core (decrypt only)
//   do_data, do_valid,
//   do_last, do_ready  : registered output stream
// ---------------------------------------------------------------------------
module lwc_postproc_lite #(
  parameter int CCW     = 32,
  parameter int CCWdiv8 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_decrypt,
  input  logic               cmd_hash,
  input  logic [15:0]        cmd_len,
  input  logic [CCW-1:0]     bdo,
  input  logic               bdo_valid,
  output logic               bdo_ready,
  input  logic [CCWdiv8-1:0] bdo_valid_bytes,
  input  logic               msg_auth_valid,
  output logic               msg_auth_ready,
  input  logic               msg_auth,
  output logic [CCW-1:0]     do_data,
  output logic               do_valid,
  input  logic               do_ready,
  output logic               do_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_TAGHDR,
    S_TAG,
    S_AUTH,
    S_STATUS
  } state_t;

  typedef enum logic [1:0] {
    OP_ENC,
    OP_DEC,
    OP_HASH
  } op_t;

  localparam logic [31:0] TAG_HDR_WORD   = 32'h8300_0010;
  localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
  localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;
  localparam logic [15:0] HASH_LEN       = 16'd32;

  state_t         state_reg, state_next;
  op_t            op_reg, op_next;
  logic [15:0]    len_reg, len_next;
  logic [15:0]    remain_reg, remain_next;
  logic [1:0]     tag_cnt_reg, tag_cnt_next;
  logic           auth_ok_reg, auth_ok_next;
  logic           status_sent_reg, status_sent_next;
  logic [CCW-1:0] do_data_reg, do_data_next;
  logic           do_valid_reg, do_valid_next;
  logic           do_last_reg, do_last_next;

  logic           out_free;
  logic           load_out;
  logic [CCW-1:0] out_word;
  logic           out_last;
  logic           cmd_ready_c;
  logic           bdo_ready_c;
  logic           auth_ready_c;
  logic [3:0]     hdr_type;
  logic [CCW-1:0] hdr_word;
  logic [CCW-1:0] bdo_masked;
  state_t         after_data_state;

  // Zero every byte lane whose valid flag is clear. Lane 0 sits in the most
  // significant byte and is flagged by the most significant valid bit.
  for (genvar gi = 0; gi < CCWdiv8; gi++) begin : g_lane
    assign bdo_masked[CCW-1-8*gi -: 8] =
      bdo_valid_bytes[CCWdiv8-1-gi] ? bdo[CCW-1-8*gi -: 8] : 8'h00;
  end

  // The output register may take a new word when it is empty or when its
  // current word is leaving this cycle.
  assign out_free = !do_valid_reg || do_ready;

  always_comb begin
    hdr_type = 4'h5;
    case (op_reg)
      OP_DEC:  hdr_type = 4'h4;
      OP_HASH: hdr_type = 4'h9;
      default: hdr_type = 4'h5;
    endcase
  end

  assign hdr_word = {hdr_type, 2'b00, 1'b1, 1'b1, 8'h00, len_reg};

  // Where to go once the message body is finished (or skipped when empty).
  always_comb begin
    after_data_state = S_TAGHDR;
    case (op_reg)
      OP_DEC:  after_data_state = S_AUTH;
      OP_HASH: after_data_state = S_STATUS;
      default: after_data_state = S_TAGHDR;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    len_next         = len_reg;
    remain_next      = remain_reg;
    tag_cnt_next     = tag_cnt_reg;
    auth_ok_next     = auth_ok_reg;
    status_sent_next = status_sent_reg;
    load_out         = 1'b0;
    out_word         = '0;
    out_last         = 1'b0;
    cmd_ready_c      = 1'b0;
    bdo_ready_c      = 1'b0;
    auth_ready_c     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          if (cmd_hash) begin
            op_next     = OP_HASH;
            len_next    = HASH_LEN;
            remain_next = HASH_LEN;
          end else begin
            op_next     = cmd_decrypt ? OP_DEC : OP_ENC;
            len_next    = cmd_len;
            remain_next = cmd_len;
          end
          tag_cnt_next     = 2'd0;
          auth_ok_next     = 1'b0;
          status_sent_next = 1'b0;
          state_next       = S_HDR;
        end
      end

      S_HDR: begin
        if (out_free) begin
          load_out   = 1'b1;
          out_word   = hdr_word;
          state_next = (len_reg == 16'd0) ? after_data_state : S_DATA;
        end
      end

      S_DATA: begin
        bdo_ready_c = out_free;
        if (bdo_valid && out_free) begin
          load_out = 1'b1;
          out_word = bdo_masked;
          if (remain_reg <= 16'd4) begin
            remain_next = 16'd0;
            state_next  = after_data_state;
          end else begin
            remain_next = remain_reg - 16'd4;
          end
        end
      end

      S_TAGHDR: begin
        if (out_free) begin
          load_out     = 1'b1;
          out_word     = TAG_HDR_WORD;
          tag_cnt_next = 2'd0;
          state_next   = S_TAG;
        end
      end

      S_TAG: begin
        // Tag words are forwarded as-is; lane masking only applies to data.
        bdo_ready_c = out_free;
        if (bdo_valid && out_free) begin
          load_out     = 1'b1;
          out_word     = bdo;
          tag_cnt_next = tag_cnt_reg + 2'd1;
          if (tag_cnt_reg == 2'd3) begin
            state_next = S_STATUS;
          end
        end
      end

      S_AUTH: begin
        auth_ready_c = 1'b1;
        if (msg_auth_valid) begin
          auth_ok_next = msg_auth;
          state_next   = S_STATUS;
        end
      end

      S_STATUS: begin
        // First load the status word, then stay here until downstream takes
        // it so that no new command can start while it is still pending.
        if (!status_sent_reg) begin
          if (out_free) begin
            load_out         = 1'b1;
            out_word         = (op_reg == OP_DEC && !auth_ok_reg) ?
                               STATUS_FAILURE : STATUS_SUCCESS;
            out_last         = 1'b1;
            status_sent_next = 1'b1;
          end
        end else if (do_valid_reg && do_ready) begin
          status_sent_next = 1'b0;
          state_next       = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output register: refreshed only when free, otherwise holds its word.
  always_comb begin
    do_valid_next = do_valid_reg;
    do_data_next  = do_data_reg;
    do_last_next  = do_last_reg;
    if (out_free) begin
      do_valid_next = load_out;
      do_last_next  = load_out ? out_last : 1'b0;
      if (load_out) begin
        do_data_next = out_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      op_reg          <= OP_ENC;
      len_reg         <= 16'd0;
      remain_reg      <= 16'd0;
      tag_cnt_reg     <= 2'd0;
      auth_ok_reg     <= 1'b0;
      status_sent_reg <= 1'b0;
      do_data_reg     <= '0;
      do_valid_reg    <= 1'b0;
      do_last_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      len_reg         <= len_next;
      remain_reg      <= remain_next;
      tag_cnt_reg     <= tag_cnt_next;
      auth_ok_reg     <= auth_ok_next;
      status_sent_reg <= status_sent_next;
      do_data_reg     <= do_data_next;
      do_valid_reg    <= do_valid_next;
      do_last_reg     <= do_last_next;
    end
  end

  // Handshake readies are forced low while reset is held.
  assign cmd_ready      = cmd_ready_c  && !rst;
  assign bdo_ready      = bdo_ready_c  && !rst;
  assign msg_auth_ready = auth_ready_c && !rst;

  assign do_data  = do_data_reg;
  assign do_valid = do_valid_reg;
  assign do_last  = do_last_reg;

endmodule

// File: doc/lwc_postproc_lite.md
LWC_POSTPROC_LITE -- requirements
Module: lwc_postproc_lite

Interface
REQ-001 Parameter CCW, default 32: width of bdo and do_data in bits; only 32 is supported.
REQ-002 Parameter CCWdiv8, default 4: byte lanes per word.
REQ-003 The clock port SHALL be: clk  in  1  single clock; all logic is on the rising edge.
REQ-004 The reset port SHALL be: rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  operation command present.
REQ-006 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 cmd_decrypt  in  1  1 = decrypt, 0 = encrypt; ignored when cmd_hash = 1.
REQ-008 cmd_hash  in  1  hash operation.
REQ-009 cmd_len  in  16  output message length in bytes; ignored for hash.
REQ-010 bdo  in  CCW  data word from the crypto core; byte 0 is in bits [31:24].
REQ-011 bdo_valid  in  1  bdo word offered.
REQ-012 bdo_ready  out  1  bdo word consumed when high together with bdo_valid.
REQ-013 bdo_valid_bytes  in  CCWdiv8  per-byte valid flags; bit 3 = byte 0.
REQ-014 msg_auth_valid  in  1  tag-check result offered.
REQ-015 msg_auth_ready  out  1  result consumed when high together with msg_auth_valid.
REQ-016 msg_auth  in  1  1 = tag matched.
REQ-017 do_data  out  CCW  output word.
REQ-018 do_valid  out  1  do_data valid.
REQ-019 do_ready  in  1  downstream accepts the word when high together with do_valid.
REQ-020 do_last  out  1  marks the status word, which is the final word of an operation.

Function
REQ-021 FSM states: IDLE, HDR, DATA, TAGHDR, TAG, AUTH, STATUS.
REQ-022 IDLE: cmd_ready = 1.
- On cmd_valid, latch op and length, then go to HDR.
- cmd_ready = 0 in every other state.
REQ-023 HDR emits one header word:
- [31:28] = type: 0x5 encrypt, 0x4 decrypt, 0x9 hash
- [27:26] = 00; [25] = 1; [24] = 1; [23:16] = 0x00
- [15:0] = length; hash length is fixed at 32
REQ-024 The remaining-byte counter SHALL load with the length.
- Each DATA word accepted subtracts min(4, remaining).
- DATA words per operation = ceil(length/4).
REQ-025 DATA: bdo_ready is high only when the output register is free or being drained.
- Each accepted bdo word is copied to do_data with invalid byte lanes zeroed, per bdo_valid_bytes.
REQ-026 On the last DATA word, or directly from HDR when length = 0:
- encrypt goes to TAGHDR
- decrypt goes to AUTH
- hash goes to STATUS
REQ-027 TAGHDR emits 0x8300_0010, then goes to TAG.
- TAG passes exactly 4 bdo words unmasked, then goes to STATUS.
REQ-028 AUTH: msg_auth_ready = 1 and bdo_ready = 0.
- Latch msg_auth on handshake, then go to STATUS.
- msg_auth_ready = 0 in every other state.
REQ-029 STATUS emits one word with do_last = 1:
- 0xE000_0000 on success, which covers encrypt, hash, and decrypt with msg_auth = 1
- 0xF000_0000 on decrypt with msg_auth = 0
- Return to IDLE when the word is accepted.
REQ-030 Output register timing:
- do_valid/do_data/do_last are registered, giving 1-cycle latency from the bdo or header decision.
- The register loads when do_valid = 0 or do_ready = 1.
- This sustains 1 word/cycle under continuous do_ready.
REQ-031 While do_valid = 1 and do_ready = 0, do_data/do_last SHALL hold stable and bdo_ready SHALL be 0.
REQ-032 A bdo word offered outside DATA/TAG SHALL NOT be consumed.
REQ-033 A new command SHALL NOT be accepted until the STATUS word has been accepted.

Reset
REQ-034 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and the counters and the latched auth result SHALL clear.
- Outputs: do_valid = 0, do_data = 0, do_last = 0, bdo_ready = 0, msg_auth_ready = 0, cmd_ready = 0.
- cmd_ready rises the cycle after rst falls.
REQ-035 Reset mid-operation SHALL discard the operation and any pending output word, with no status word emitted.

Verification
REQ-036 Encrypt, cmd_len = 5, bdo words 0x11223344 (valid 1111) and 0x55AABBCC (valid 1000), tag words T0..T3, do_ready = 1 -> 0x5300_0005, 0x11223344, 0x5500_0000, 0x8300_0010, T0..T3, 0xE000_0000 with do_last = 1.
REQ-037 Decrypt, cmd_len = 0, msg_auth = 0 -> 0x4300_0000, then 0xF000_0000 with do_last = 1; bdo_ready is never high.
REQ-038 Hash with 8 digest words -> 0x9300_0020, the 8 words in order, 0xE000_0000; bdo_ready drops after the 8th word.
REQ-039 Encrypt cmd_len = 8 with do_ready toggling 1/0 each cycle -> no word lost or duplicated, do_data stable while stalled, and cmd_ready = 0 until the status word is accepted.
REQ-040 rst asserted during DATA of a 64-byte encrypt -> next cycle do_valid = 0; the next command produces a fresh header with no residual words.
